// File: rtl/multi_alarm_clock_pkg.sv
// Shared types, limits and BCD helpers for the multi-alarm clock.
// Used by every other file through a package import.
package multi_alarm_clock_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_RINGING = 2'd1,
    CH_SNOOZED = 2'd2
  } ch_state_t;

  localparam int MIN_PER_DAY   = 1440;
  localparam int MODW          = 11;
  localparam int HOUR_TENS_MAX = 2;
  localparam int HOUR_LAST_MAX = 3;
  localparam int UNIT_MAX      = 9;
  localparam int TENS_MAX      = 5;

  function automatic logic bcd_valid(
    input logic [1:0] h1,
    input logic [3:0] h0,
    input logic [3:0] m1,
    input logic [3:0] m0
  );
    logic hr_ok;
    hr_ok = (32'(h1) < HOUR_TENS_MAX)
         || (32'(h1) == HOUR_TENS_MAX
             && 32'(h0) <= HOUR_LAST_MAX);
    return hr_ok
        && 32'(h0) <= UNIT_MAX
        && 32'(m1) <= TENS_MAX
        && 32'(m0) <= UNIT_MAX;
  endfunction

  function automatic logic [MODW-1:0] bcd_to_mod(
    input logic [1:0] h1,
    input logic [3:0] h0,
    input logic [3:0] m1,
    input logic [3:0] m0
  );
    logic [MODW-1:0] hr;
    logic [MODW-1:0] mn;
    hr = MODW'(h1) * MODW'(10) + MODW'(h0);
    mn = MODW'(m1) * MODW'(10) + MODW'(m0);
    return hr * MODW'(60) + mn;
  endfunction

endpackage

// File: rtl/multi_alarm_clock_if.sv
// Control/load bus of the multi-alarm clock.
// master drives the BCD value and commands, slave is the clock.
interface multi_alarm_clock_if
  import multi_alarm_clock_pkg::*;
#(
  parameter int NUM_ALARMS = 4
) ();
  localparam int SELW =
    (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic [1:0]      h_in1;
  logic [3:0]      h_in0;
  logic [3:0]      m_in1;
  logic [3:0]      m_in0;
  logic            set_time;
  logic            set_alarm;
  logic [SELW-1:0] alarm_sel;
  logic            arm;
  logic            stop_alarm;
  logic            snooze;

  modport master (
    output h_in1, h_in0, m_in1, m_in0,
    output set_time, set_alarm, alarm_sel,
    output arm, stop_alarm, snooze
  );

  modport slave (
    input h_in1, h_in0, m_in1, m_in0,
    input set_time, set_alarm, alarm_sel,
    input arm, stop_alarm, snooze
  );
endinterface

// File: rtl/multi_alarm_clock_alarm_channel.sv
// One alarm channel: alarm time, enable, ring state, snooze deadline.
// Snooze exists only when MULTI_ALARM_SNOOZE_EN is defined.
module alarm_channel
  import multi_alarm_clock_pkg::*;
#(
  parameter int SNOOZE_MIN = 5
) (
  input  logic            clk_1s,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_arm,
  input  logic [1:0]      i_h1,
  input  logic [3:0]      i_h0,
  input  logic [3:0]      i_m1,
  input  logic [3:0]      i_m0,
  input  logic [MODW-1:0] i_cur_mod,
  input  logic            i_sec_zero,
  input  logic            i_stop,
  input  logic            i_snooze,
  output logic            o_ringing
);
  logic [MODW-1:0] r_alarm_mod;
  logic            r_en;
  ch_state_t       r_state;
  ch_state_t       w_next;
  logic            w_match;

  assign w_match = r_en && i_sec_zero
                && (i_cur_mod == r_alarm_mod);
  assign o_ringing = (r_state == CH_RINGING);

`ifdef MULTI_ALARM_SNOOZE_EN
  logic [MODW-1:0] r_deadline;
  logic [MODW-1:0] w_dl_sum;
  logic [MODW-1:0] w_dl_calc;
  logic            w_dl_hit;

  assign w_dl_sum  = i_cur_mod + MODW'(SNOOZE_MIN);
  assign w_dl_calc = (w_dl_sum >= MODW'(MIN_PER_DAY))
                   ? w_dl_sum - MODW'(MIN_PER_DAY)
                   : w_dl_sum;
  assign w_dl_hit  = i_sec_zero
                  && (i_cur_mod == r_deadline);

  // Capture the wake-up minute when the channel enters snooze.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) r_deadline <= '0;
    else if (r_state == CH_RINGING
             && w_next == CH_SNOOZED)
      r_deadline <= w_dl_calc;
  end
`else
  logic w_unused_snooze;
  assign w_unused_snooze = i_snooze;
`endif

  // Alarm time and enable written by set_alarm.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_alarm_mod <= '0;
      r_en        <= 1'b0;
    end else if (i_load) begin
      r_alarm_mod <= bcd_to_mod(i_h1, i_h0, i_m1, i_m0);
      r_en        <= i_arm;
    end
  end

  // Channel state register.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) r_state <= CH_IDLE;
    else       r_state <= w_next;
  end

  // Next state: load > stop > snooze > match/deadline.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CH_IDLE: if (w_match) w_next = CH_RINGING;
      CH_RINGING: begin
`ifdef MULTI_ALARM_SNOOZE_EN
        if (i_snooze) w_next = CH_SNOOZED;
`endif
      end
      CH_SNOOZED: begin
`ifdef MULTI_ALARM_SNOOZE_EN
        if (w_dl_hit) w_next = CH_RINGING;
`else
        w_next = CH_IDLE;
`endif
      end
      default: w_next = CH_IDLE;
    endcase
    if (i_stop) w_next = CH_IDLE;
    if (i_load) w_next = CH_IDLE;
  end
endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour BCD clock with NUM_ALARMS independent alarm channels.
// Optional snooze: define MULTI_ALARM_SNOOZE_EN.
module multi_alarm_clock
  import multi_alarm_clock_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                  clk_1s,
  input  logic                  reset,
  multi_alarm_clock_if.slave    bus,
  output logic                  alarm_on,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic [1:0]            H_out1,
  output logic [3:0]            H_out0,
  output logic [2:0]            M_out1,
  output logic [3:0]            M_out0,
  output logic [2:0]            S_out1,
  output logic [3:0]            S_out0
);
  localparam int SELW =
    (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic [1:0]      r_h1;
  logic [3:0]      r_h0;
  logic [2:0]      r_m1;
  logic [3:0]      r_m0;
  logic [2:0]      r_s1;
  logic [3:0]      r_s0;
  logic            w_bcd_ok;
  logic            w_h_wrap;
  logic [MODW-1:0] w_cur_mod;
  logic            w_sec_zero;

  assign w_bcd_ok = bcd_valid(bus.h_in1, bus.h_in0,
                              bus.m_in1, bus.m_in0);
  assign w_h_wrap = (r_h1 == 2'd2) && (r_h0 == 4'd3);
  assign w_cur_mod = bcd_to_mod(r_h1, r_h0,
                                {1'b0, r_m1}, r_m0);
  assign w_sec_zero = (r_s1 == 3'd0) && (r_s0 == 4'd0);

  // Time of day: load on valid set_time, else count seconds.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_h1 <= '0; r_h0 <= '0;
      r_m1 <= '0; r_m0 <= '0;
      r_s1 <= '0; r_s0 <= '0;
    end else if (bus.set_time && w_bcd_ok) begin
      r_h1 <= bus.h_in1;
      r_h0 <= bus.h_in0;
      r_m1 <= bus.m_in1[2:0];
      r_m0 <= bus.m_in0;
      r_s1 <= '0;
      r_s0 <= '0;
    end else if (r_s0 != 4'd9) begin
      r_s0 <= r_s0 + 4'd1;
    end else begin
      r_s0 <= '0;
      if (r_s1 != 3'd5) r_s1 <= r_s1 + 3'd1;
      else begin
        r_s1 <= '0;
        if (r_m0 != 4'd9) r_m0 <= r_m0 + 4'd1;
        else begin
          r_m0 <= '0;
          if (r_m1 != 3'd5) r_m1 <= r_m1 + 3'd1;
          else begin
            r_m1 <= '0;
            if (w_h_wrap) begin
              r_h1 <= '0;
              r_h0 <= '0;
            end else if (r_h0 == 4'd9) begin
              r_h0 <= '0;
              r_h1 <= r_h1 + 2'd1;
            end else begin
              r_h0 <= r_h0 + 4'd1;
            end
          end
        end
      end
    end
  end

  assign H_out1 = r_h1;
  assign H_out0 = r_h0;
  assign M_out1 = r_m1;
  assign M_out0 = r_m0;
  assign S_out1 = r_s1;
  assign S_out0 = r_s0;

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    logic w_load;
    assign w_load = bus.set_alarm && w_bcd_ok
                 && (bus.alarm_sel == SELW'(g));
    alarm_channel #(
      .SNOOZE_MIN (SNOOZE_MIN)
    ) u_ch (
      .clk_1s     (clk_1s),
      .reset      (reset),
      .i_load     (w_load),
      .i_arm      (bus.arm),
      .i_h1       (bus.h_in1),
      .i_h0       (bus.h_in0),
      .i_m1       (bus.m_in1),
      .i_m0       (bus.m_in0),
      .i_cur_mod  (w_cur_mod),
      .i_sec_zero (w_sec_zero),
      .i_stop     (bus.stop_alarm),
      .i_snooze   (bus.snooze),
      .o_ringing  (ringing[g])
    );
  end

  assign alarm_on = |ringing;
endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 Parameter NUM_ALARMS, default 4, number of independent alarm channels (1..8).
REQ-002 Parameter SNOOZE_MIN, default 5, snooze delay in minutes (1..59).
REQ-003 clk_1s  input  1  one-second tick clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 h_in1/h_in0/m_in1/m_in0  input  2/4/4/4  BCD hour-tens, hour-units, minute-tens, minute-units load value.
REQ-006 set_time  input  1  load current time from BCD inputs.
REQ-007 set_alarm  input  1  load alarm channel alarm_sel from BCD inputs.
REQ-008 alarm_sel  input  $clog2(NUM_ALARMS) (min 1)  channel index for set_alarm and arm.
REQ-009 arm  input  1  with set_alarm: value written to the channel's enable bit.
REQ-010 stop_alarm  input  1  silence all channels.
REQ-011 snooze  input  1  snooze all ringing channels.
REQ-012 alarm_on  output  1  OR of all channels in RINGING.
REQ-013 ringing  output  NUM_ALARMS  per-channel RINGING flags.
REQ-014 H_out1/H_out0/M_out1/M_out0/S_out1/S_out0  output  2/4/3/4/3/4  current time, BCD, registered.

Function
REQ-015 Time counter SHALL hold hours 00..23, minutes 00..59, seconds 00..59 in BCD, advancing by one second per clk_1s edge.
REQ-016 Wrap: x9->x0 with tens carry; 59 s->00 with minute carry; 59 min->00 with hour carry; 23:59:59->00:00:00.
REQ-017 set_time SHALL load HH:MM from inputs and clear seconds to 00 on the same edge, overriding counting.
REQ-018 set_time or set_alarm with invalid BCD (hour>23, any unit>9, minute-tens>5) SHALL be ignored entirely.
REQ-019 set_alarm SHALL write HH:MM and enable=arm into channel alarm_sel only; alarm_sel>=NUM_ALARMS ignored.
REQ-020 Channel states: IDLE, RINGING, SNOOZED.
REQ-021 Match: registered time equals channel HH:MM, seconds==00, enable=1.
REQ-022 IDLE->RINGING on the edge where match holds (one clk_1s after time reaches HH:MM:00); ringing/alarm_on registered.
REQ-023 RINGING->SNOOZED on snooze; deadline = current minute-of-day + SNOOZE_MIN, modulo 1440.
REQ-024 SNOOZED->RINGING on the edge where current minute-of-day equals deadline and seconds==00.
REQ-025 RINGING or SNOOZED->IDLE on stop_alarm; IDLE channels unaffected.
REQ-026 Priority per edge: stop_alarm > snooze > match/deadline.
REQ-027 set_alarm on a RINGING or SNOOZED channel SHALL force it to IDLE.
REQ-028 set_time does not itself trigger; match evaluates against loaded time from the next edge.
REQ-029 Channels sharing HH:MM ring together; each tracked independently.

Reset
REQ-030 reset SHALL set time 00:00:00, all alarms 00:00 disabled, all channels IDLE, alarm_on=0, ringing=0, immediately.
REQ-031 Reset mid-ring or mid-snooze SHALL discard the pending deadline.

Configuration
REQ-032 Macro MULTI_ALARM_SNOOZE_EN defined: snooze per REQ-023/024.
REQ-033 Undefined: snooze input ignored, SNOOZED unreachable, no deadline registers; all else unchanged.

Structure
REQ-034 Package multi_alarm_clock_pkg SHALL hold channel state enum, MIN_PER_DAY=1440, BCD limit constants, and BCD-to-minute-of-day function.
REQ-035 Sub-module alarm_channel SHALL hold one channel's alarm registers, enable, state and deadline; instantiated NUM_ALARMS times via generate.

Verification
REQ-036 reset, set_time 23:59, run 60 edges -> outputs 00:00:00 after the 60th edge.
REQ-037 Ch0 armed 07:30, time set 07:29, run 61 edges -> ringing[0]=1 and alarm_on=1 exactly at 07:30:01; stop_alarm -> 0 next edge.
REQ-038 Ch1 armed 23:58, ringing, snooze at 23:58:10 (SNOOZE_MIN=5) -> SNOOZED; re-rings at 00:03:01.
REQ-039 Ch0 and ch2 both 06:00, stop_alarm and snooze asserted same edge while ringing -> both IDLE.
REQ-040 set_time h_in1=2, h_in0=5 -> ignored, time unchanged; set_alarm arm=0 at matching time -> no ring.
REQ-041 Build without MULTI_ALARM_SNOOZE_EN: snooze while ringing -> stays RINGING.
